// File: rtl/lfsr_period_checker_if.sv
// Handshake bundle between an LFSR state source and the period checker.
// The source side drives start/state_valid/state_in; the checker returns status.
interface lfsr_period_checker_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             state_valid;
  logic [WIDTH-1:0] state_in;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   period;
  logic             maximal;
  logic             lockup;
  logic             timeout;

  modport master (
    output start, state_valid, state_in,
    input  busy, done, period, maximal, lockup, timeout
  );

  modport slave (
    input  start, state_valid, state_in,
    output busy, done, period, maximal, lockup, timeout
  );
endinterface

// File: rtl/lfsr_period_checker.sv
// Measures the recurrence period of an LFSR state stream and flags
// maximal-length, all-zero lockup, and no-recurrence (timeout) outcomes.
module lfsr_period_checker #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  lfsr_period_checker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

  localparam logic [WIDTH:0] FULL  = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] MAX_P = FULL - 1'b1;

  state_t           state, state_next;
  logic [WIDTH-1:0] ref_state, ref_next;
  logic [WIDTH:0]   cnt, cnt_next;
  logic [WIDTH:0]   n;
  logic [WIDTH:0]   period_next;
  logic             maximal_next, lockup_next, timeout_next;
  logic             busy_next, done_next;

  assign n = cnt + 1'b1;

  always_comb begin
    state_next   = state;
    ref_next     = ref_state;
    cnt_next     = cnt;
    period_next  = bus.period;
    maximal_next = bus.maximal;
    lockup_next  = bus.lockup;
    timeout_next = bus.timeout;

    case (state)
      IDLE: begin
        if (bus.start) state_next = ARM;
      end
      ARM: begin
        if (bus.state_valid) begin
          ref_next = bus.state_in;
          cnt_next = '0;
          if (bus.state_in == '0) begin
            lockup_next = 1'b1;
            period_next = '0;
            state_next  = DONE;
          end else begin
            state_next = COUNT;
          end
        end
      end
      COUNT: begin
        // Recurrence wins over lockup, which wins over timeout.
        if (bus.state_valid) begin
          if (bus.state_in == ref_state) begin
            period_next  = n;
            maximal_next = (n == MAX_P);
            state_next   = DONE;
          end else if (bus.state_in == '0) begin
            lockup_next = 1'b1;
            period_next = n;
            state_next  = DONE;
          end else if (n == FULL) begin
            timeout_next = 1'b1;
            period_next  = n;
            state_next   = DONE;
          end else begin
            cnt_next = n;
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          period_next  = '0;
          maximal_next = 1'b0;
          lockup_next  = 1'b0;
          timeout_next = 1'b0;
          state_next   = ARM;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == ARM) || (state_next == COUNT);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      ref_state   <= '0;
      cnt         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.period  <= '0;
      bus.maximal <= 1'b0;
      bus.lockup  <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      state       <= state_next;
      ref_state   <= ref_next;
      cnt         <= cnt_next;
      bus.busy    <= busy_next;
      bus.done    <= done_next;
      bus.period  <= period_next;
      bus.maximal <= maximal_next;
      bus.lockup  <= lockup_next;
      bus.timeout <= timeout_next;
    end
  end

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Directed bench for lfsr_period_checker: table of streams with hand-computed
// results plus sequences for stalls, start-while-busy, re-arm and mid-run reset.
module tb_lfsr_period_checker;

  localparam int W = 4;

  typedef struct {
    string      name;
    logic [3:0] seq [20];
    int         len;
    int         exp_period;
    int         exp_max;
    int         exp_lock;
    int         exp_to;
    int         exp_samples;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [5];

  lfsr_period_checker_if #(.WIDTH(W)) bus ();

  lfsr_period_checker #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Feeds v.seq cyclically until done, optionally inserting idle cycles and a
  // start pulse mid-measurement; reports how many valid samples were consumed.
  task automatic feed(input vec_t v, input bit stalls, input bit poke,
                      output int used);
    int cyc;
    used = 0;
    cyc  = 0;
    while (!bus.done && cyc < 200) begin
      if (stalls && $urandom_range(0, 2) == 0) begin
        bus.state_valid = 1'b0;
      end else begin
        bus.state_valid = 1'b1;
        bus.state_in    = v.seq[used % v.len];
        used++;
      end
      bus.start = poke && (cyc == 6);
      tick();
      cyc++;
    end
    bus.state_valid = 1'b0;
    bus.start       = 1'b0;
  endtask

  task automatic check_result(input vec_t v, input int used);
    check({v.name, " done"},    int'(bus.done),    1);
    check({v.name, " period"},  int'(bus.period),  v.exp_period);
    check({v.name, " maximal"}, int'(bus.maximal), v.exp_max);
    check({v.name, " lockup"},  int'(bus.lockup),  v.exp_lock);
    check({v.name, " timeout"}, int'(bus.timeout), v.exp_to);
    check({v.name, " busy"},    int'(bus.busy),    0);
    check({v.name, " samples"}, used,              v.exp_samples);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"},    int'(bus.busy),    0);
    check({tag, " done"},    int'(bus.done),    0);
    check({tag, " period"},  int'(bus.period),  0);
    check({tag, " maximal"}, int'(bus.maximal), 0);
    check({tag, " lockup"},  int'(bus.lockup),  0);
    check({tag, " timeout"}, int'(bus.timeout), 0);
  endtask

  initial begin
    logic [3:0] s;
    int used;

    reset           = 1'b0;
    bus.start       = 1'b0;
    bus.state_valid = 1'b0;
    bus.state_in    = '0;

    // x^4+x^3+1 Fibonacci LFSR from 0001: 15 distinct non-zero states.
    vecs[0].name = "maximal";
    s = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      vecs[0].seq[i] = s;
      s = {s[2:0], s[3] ^ s[2]};
    end
    vecs[0].len = 15; vecs[0].exp_period = 15; vecs[0].exp_max = 1;
    vecs[0].exp_lock = 0; vecs[0].exp_to = 0; vecs[0].exp_samples = 16;

    vecs[1].name = "nonmax";
    for (int i = 0; i < 20; i++) vecs[1].seq[i] = 4'd0;
    vecs[1].seq[0] = 4'd3;  vecs[1].seq[1] = 4'd7; vecs[1].seq[2] = 4'd9;
    vecs[1].seq[3] = 4'd2;  vecs[1].seq[4] = 4'd5; vecs[1].seq[5] = 4'd11;
    vecs[1].len = 6; vecs[1].exp_period = 6; vecs[1].exp_max = 0;
    vecs[1].exp_lock = 0; vecs[1].exp_to = 0; vecs[1].exp_samples = 7;

    vecs[2].name = "lockA";
    for (int i = 0; i < 20; i++) vecs[2].seq[i] = 4'd0;
    vecs[2].len = 1; vecs[2].exp_period = 0; vecs[2].exp_max = 0;
    vecs[2].exp_lock = 1; vecs[2].exp_to = 0; vecs[2].exp_samples = 1;

    vecs[3].name = "lockB";
    for (int i = 0; i < 20; i++) vecs[3].seq[i] = 4'd0;
    vecs[3].seq[0] = 4'd5; vecs[3].seq[1] = 4'd6;
    vecs[3].len = 3; vecs[3].exp_period = 2; vecs[3].exp_max = 0;
    vecs[3].exp_lock = 1; vecs[3].exp_to = 0; vecs[3].exp_samples = 3;

    vecs[4].name = "timeout";
    for (int i = 0; i < 20; i++) vecs[4].seq[i] = 4'd5;
    vecs[4].seq[0] = 4'd1;
    vecs[4].len = 20; vecs[4].exp_period = 16; vecs[4].exp_max = 0;
    vecs[4].exp_lock = 0; vecs[4].exp_to = 1; vecs[4].exp_samples = 17;

    repeat (3) tick();
    check_idle("reset");
    reset = 1'b1;
    tick();
    check_idle("post-reset");

    for (int i = 0; i < 5; i++) begin
      pulse_start();
      check({vecs[i].name, " armed busy"}, int'(bus.busy), 1);
      check({vecs[i].name, " armed done"}, int'(bus.done), 0);
      feed(vecs[i], 1'b0, 1'b0, used);
      check_result(vecs[i], used);
    end

    // Random stalls plus a start pulse while counting must not disturb the result.
    pulse_start();
    feed(vecs[0], 1'b1, 1'b1, used);
    check_result(vecs[0], used);

    // Start from DONE clears results on the same edge and re-arms.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("rearm done",    int'(bus.done),    0);
    check("rearm period",  int'(bus.period),  0);
    check("rearm maximal", int'(bus.maximal), 0);
    check("rearm lockup",  int'(bus.lockup),  0);
    check("rearm timeout", int'(bus.timeout), 0);
    check("rearm busy",    int'(bus.busy),    1);
    feed(vecs[0], 1'b0, 1'b0, used);
    check_result(vecs[0], used);

    // Reset on the 7th sample of a maximal run, then a clean rerun.
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      bus.state_valid = 1'b1;
      bus.state_in    = vecs[0].seq[i];
      tick();
    end
    check("midrun busy", int'(bus.busy), 1);
    bus.state_in = vecs[0].seq[6];
    reset = 1'b0;
    tick();
    check_idle("midreset");
    reset           = 1'b1;
    bus.state_valid = 1'b0;
    tick();
    check_idle("after reset");
    pulse_start();
    feed(vecs[0], 1'b0, 1'b0, used);
    check_result(vecs[0], used);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
